// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a 16-entry note table and drives the tone
// select and enable of a sine PWM generator, one entry at a time.
module melody_sequencer #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [11:0] wr_data,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  posT,
  output logic        tone_en,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned GW = $clog2(GAP_TICKS + 1);
  // Shared count register holds either a note duration (7 bits) or GAP_TICKS.
  localparam int unsigned CW = (GW > 7) ? GW : 7;

  typedef enum logic [1:0] {StIdle, StFetch, StPlay, StGap} state_e;

  state_e          r_state;
  logic [11:0]     r_table [16];
  logic [3:0]      r_addr;
  logic [TW-1:0]   r_tick;
  logic [CW-1:0]   r_cnt;
  logic            r_last;
  logic [3:0]      r_posT;
  logic            r_tone_en;
  logic            r_busy;
  logic            r_done;

  logic [11:0]     w_entry;
  logic [6:0]      w_dur;
  logic            w_tick_wrap;
  logic            w_cnt_last;
  logic            w_last_sel;
  logic            w_finish;
  state_e          w_adv_state;
  logic [3:0]      w_adv_addr;

  // In FETCH the last flag comes straight from the table; afterwards from the latch.
  assign w_entry     = r_table[r_addr];
  assign w_dur       = w_entry[10:4];
  assign w_tick_wrap = (r_tick == TW'(TICK_DIV - 1));
  assign w_cnt_last  = (r_cnt == CW'(1));
  assign w_last_sel  = (r_state == StFetch) ? w_entry[11] : r_last;
  assign w_finish    = w_last_sel || (r_addr == 4'hF);
  assign w_adv_state = w_finish ? StIdle : StFetch;
  assign w_adv_addr  = w_finish ? r_addr : r_addr + 4'd1;

  assign posT    = r_posT;
  assign tone_en = r_tone_en;
  assign busy    = r_busy;
  assign done    = r_done;

  // Note table: written in any state, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_table[i] <= 12'h000;
      end
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // Playback FSM with registered outputs; stop wins over start and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= 4'd0;
      r_tick    <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_posT    <= 4'd0;
      r_tone_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start && !stop) begin
            r_addr  <= 4'd0;
            r_state <= StFetch;
            r_busy  <= 1'b1;
          end
        end
        StFetch: begin
          if (stop) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_tone_en <= 1'b0;
          end else begin
            r_last <= w_entry[11];
            if (w_dur != 7'd0) begin
              r_state   <= StPlay;
              r_tick    <= '0;
              r_cnt     <= CW'(w_dur);
              r_posT    <= w_entry[3:0];
              r_tone_en <= 1'b1;
            end else begin
              // Zero-duration entry is skipped without sounding.
              r_state <= w_adv_state;
              r_addr  <= w_adv_addr;
              r_busy  <= !w_finish;
              r_done  <= w_finish;
            end
          end
        end
        StPlay: begin
          if (stop) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_tone_en <= 1'b0;
          end else if (w_tick_wrap) begin
            r_tick <= '0;
            if (w_cnt_last) begin
              r_tone_en <= 1'b0;
              if (GAP_TICKS != 0) begin
                r_state <= StGap;
                r_cnt   <= CW'(GAP_TICKS);
              end else begin
                r_state <= w_adv_state;
                r_addr  <= w_adv_addr;
                r_busy  <= !w_finish;
                r_done  <= w_finish;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        StGap: begin
          if (stop) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_tone_en <= 1'b0;
          end else if (w_tick_wrap) begin
            r_tick <= '0;
            if (w_cnt_last) begin
              r_state <= w_adv_state;
              r_addr  <= w_adv_addr;
              r_busy  <= !w_finish;
              r_done  <= w_finish;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer (TICK_DIV=4, GAP_TICKS=1). Each cycle's
// outputs are compared as {busy, done, tone_en, posT} against hand-written traces.
module tb_melody_sequencer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        start;
  logic        stop;
  logic [3:0]  posT;
  logic        tone_en;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  melody_sequencer #(
    .TICK_DIV  (4),
    .GAP_TICKS (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .posT    (posT),
    .tone_en (tone_en),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ev(input logic b, input logic d, input logic t,
                                    input logic [3:0] p);
    return {b, d, t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, checking the packed outputs after each edge.
  task automatic expect_seg(input string tag, input int n, input logic [6:0] e);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq(tag, {25'd0, busy, done, tone_en, posT}, {25'd0, e});
    end
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 12'd0;
    start   = 1'b0;
    stop    = 1'b0;
    expect_seg("reset", 2, ev(0, 0, 0, 4'd0));
    rst = 1'b0;

    // Two-note melody; inter-note silence is the gap plus the fetch cycle.
    write_entry(4'd0, 12'h023);
    write_entry(4'd1, 12'h817);
    start = 1'b1;
    expect_seg("m2_fetch0", 1, ev(1, 0, 0, 4'd0));
    start = 1'b0;
    expect_seg("m2_play0", 8, ev(1, 0, 1, 4'd3));
    expect_seg("m2_gap0", 4, ev(1, 0, 0, 4'd3));
    expect_seg("m2_fetch1", 1, ev(1, 0, 0, 4'd3));
    expect_seg("m2_play1", 4, ev(1, 0, 1, 4'd7));
    expect_seg("m2_gap1", 4, ev(1, 0, 0, 4'd7));
    expect_seg("m2_done", 1, ev(0, 1, 0, 4'd7));
    expect_seg("m2_idle", 2, ev(0, 0, 0, 4'd7));

    // Stop mid-note.
    start = 1'b1;
    expect_seg("stop_fetch", 1, ev(1, 0, 0, 4'd7));
    start = 1'b0;
    expect_seg("stop_play", 3, ev(1, 0, 1, 4'd3));
    stop = 1'b1;
    expect_seg("stop_idle", 1, ev(0, 0, 0, 4'd3));
    stop = 1'b0;
    expect_seg("stop_nodone", 20, ev(0, 0, 0, 4'd3));

    // Zero-duration skip, plus writes to the playing entry.
    write_entry(4'd0, 12'h005);
    write_entry(4'd1, 12'h812);
    start = 1'b1;
    expect_seg("skip_fetch0", 1, ev(1, 0, 0, 4'd3));
    start = 1'b0;
    expect_seg("skip_fetch1", 1, ev(1, 0, 0, 4'd3));
    wr_en   = 1'b1;
    wr_addr = 4'd1;
    wr_data = 12'h8F9;
    expect_seg("skip_play_wr", 1, ev(1, 0, 1, 4'd2));
    wr_en = 1'b0;
    expect_seg("skip_play", 3, ev(1, 0, 1, 4'd2));
    expect_seg("skip_gap", 4, ev(1, 0, 0, 4'd2));
    expect_seg("skip_done", 1, ev(0, 1, 0, 4'd2));
    expect_seg("skip_idle", 2, ev(0, 0, 0, 4'd2));

    // Table-end wrap: 16 one-tick notes, no last flag.
    for (int i = 0; i < 16; i++) begin
      write_entry(i[3:0], {1'b0, 7'd1, i[3:0]});
    end
    start = 1'b1;
    expect_seg("wrap_fetch", 1, ev(1, 0, 0, 4'd2));
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) expect_seg("wrap_fetch", 1, ev(1, 0, 0, 4'(i - 1)));
      expect_seg("wrap_play", 4, ev(1, 0, 1, i[3:0]));
      expect_seg("wrap_gap", 4, ev(1, 0, 0, i[3:0]));
    end
    expect_seg("wrap_done", 1, ev(0, 1, 0, 4'd15));
    expect_seg("wrap_idle", 3, ev(0, 0, 0, 4'd15));

    // Start held while busy must not restart.
    start = 1'b1;
    expect_seg("busy_fetch", 1, ev(1, 0, 0, 4'd15));
    expect_seg("busy_play0", 4, ev(1, 0, 1, 4'd0));
    expect_seg("busy_gap0", 4, ev(1, 0, 0, 4'd0));
    expect_seg("busy_fetch1", 1, ev(1, 0, 0, 4'd0));
    start = 1'b0;
    expect_seg("busy_play1", 4, ev(1, 0, 1, 4'd1));
    stop = 1'b1;
    expect_seg("busy_stop", 1, ev(0, 0, 0, 4'd1));
    stop = 1'b0;
    expect_seg("busy_idle", 3, ev(0, 0, 0, 4'd1));

    // Start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    expect_seg("ss_idle", 1, ev(0, 0, 0, 4'd1));
    start = 1'b0;
    stop  = 1'b0;
    expect_seg("ss_idle2", 2, ev(0, 0, 0, 4'd1));

    // Reset mid-GAP, with start and a write competing.
    start = 1'b1;
    expect_seg("rst_fetch", 1, ev(1, 0, 0, 4'd1));
    start = 1'b0;
    expect_seg("rst_play", 4, ev(1, 0, 1, 4'd0));
    expect_seg("rst_gap", 2, ev(1, 0, 0, 4'd0));
    rst     = 1'b1;
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 12'h8FA;
    expect_seg("rst_out", 1, ev(0, 0, 0, 4'd0));
    rst   = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    expect_seg("rst_idle", 1, ev(0, 0, 0, 4'd0));

    // Cleared table: every entry is zero-duration, so all 16 are skipped.
    start = 1'b1;
    expect_seg("clr_fetch", 1, ev(1, 0, 0, 4'd0));
    start = 1'b0;
    expect_seg("clr_fetch", 15, ev(1, 0, 0, 4'd0));
    expect_seg("clr_done", 1, ev(0, 1, 0, 4'd0));
    expect_seg("clr_idle", 2, ev(0, 0, 0, 4'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
